// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake stage states and MEM/WB payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam int unsigned MEMWB_DATA_W = 101;
  localparam int unsigned MEMWB_CTRL_W = 3;

  // MEM/WB data vector: {loadData, sum_out, result, rd}
  localparam int unsigned MEMWB_RD_LSB       = 0;
  localparam int unsigned MEMWB_RD_W         = 5;
  localparam int unsigned MEMWB_RESULT_LSB   = 5;
  localparam int unsigned MEMWB_SUM_LSB      = 37;
  localparam int unsigned MEMWB_LOADDATA_LSB = 69;
  localparam int unsigned MEMWB_WORD_W       = 32;

  // MEM/WB control vector: {controlRF, we}
  localparam int unsigned MEMWB_WE_LSB       = 0;
  localparam int unsigned MEMWB_CONTROLRF_LSB = 1;
  localparam int unsigned MEMWB_CONTROLRF_W  = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and optional
// 2-entry skid buffer; control bits are zeroed whenever the slot holds no beat.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 101,
  parameter int unsigned CTRL_W  = 3,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;

  logic w_accept;
  logic w_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;
  logic w_clr_main;
  logic w_clr_skid;

  // Skid mode registers in_ready from state alone; single mode passes out_ready through.
  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = SKID_EN ? (r_state != ST_SKID) : (out_ready | ~out_valid);
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign occ       = r_state;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    w_clr_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_clr_main  = 1'b1;
      w_clr_skid  = 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_FULL;
            w_ld_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && w_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept && SKID_EN) begin
            w_state_nxt = ST_SKID;
            w_ld_skid   = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
            w_clr_main  = 1'b1;
          end
        end
        ST_SKID: begin
          if (w_fire) begin
            w_state_nxt    = ST_FULL;
            w_ld_main_skid = 1'b1;
            w_clr_skid     = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end else if (w_clr_main) begin
        r_main_ctrl <= '0;
      end
      if (w_ld_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end else if (w_clr_skid) begin
        r_skid_ctrl <= '0;
      end
    end
  end

endmodule
